// File: rtl/axi4_wr_mem_slave.sv
// AXI4 write-channel slave driving a synchronous SRAM write port, one burst at a time.
// Optional: define AXI_WR_MEM_LANE_MASK_EN to restrict mem_be to the active narrow-transfer lanes.
module axi4_wr_mem_slave #(
   parameter int ID_W   = 1,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MEM_AW = 10
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   input  logic [ID_W-1:0]     AWID,
   input  logic                AWVALID,
   output logic                AWREADY,
   input  logic [ADDR_W-1:0]   AWADDR,
   input  logic [7:0]          AWLEN,
   input  logic [2:0]          AWSIZE,
   input  logic [1:0]          AWBURST,
   input  logic                WVALID,
   output logic                WREADY,
   input  logic [DATA_W-1:0]   WDATA,
   input  logic [DATA_W/8-1:0] WSTRB,
   input  logic                WLAST,
   output logic [ID_W-1:0]     BID,
   output logic                BVALID,
   input  logic                BREADY,
   output logic [1:0]          BRESP,
   output logic                mem_we,
   output logic [MEM_AW-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be
);
   localparam int STRB_W = DATA_W / 8;
   localparam int LB = $clog2(STRB_W);
   localparam logic [2:0] LB3 = 3'(LB);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

   state_t              r_state;
   logic [ID_W-1:0]     r_id;
   logic [ADDR_W-1:0]   r_addr;
   logic [7:0]          r_len;
   logic [2:0]          r_size;
   logic [1:0]          r_burst;
   logic [7:0]          r_cnt;
   logic [1:0]          r_resp;
   logic                r_wsup;
   logic                r_awready;
   logic                r_wready;
   logic                r_bvalid;
   logic [ID_W-1:0]     r_bid;
   logic [1:0]          r_bresp;
   logic                r_mem_we;
   logic [MEM_AW-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [STRB_W-1:0]   r_mem_be;

   logic                w_slverr;
   logic                w_decerr;
   logic [ADDR_W-1:0]   w_size_mask;
   logic [ADDR_W-1:0]   w_incr_addr;
   logic [ADDR_W-1:0]   w_wrap_mask;
   logic [ADDR_W-1:0]   w_addr_next;
   logic                w_last_beat;
   logic [1:0]          w_resp_fin;
   logic [STRB_W-1:0]   w_be;

   assign w_slverr = (AWBURST == 2'b11) || (AWSIZE > LB3) ||
                     ((AWBURST == 2'b10) && !((AWLEN == 8'd1) || (AWLEN == 8'd3) ||
                                              (AWLEN == 8'd7) || (AWLEN == 8'd15)));
   assign w_decerr = |(AWADDR >> (MEM_AW + LB));

   assign w_size_mask = (ADDR_W'(1) << r_size) - ADDR_W'(1);
   assign w_incr_addr = (r_addr & ~w_size_mask) + (ADDR_W'(1) << r_size);
   assign w_wrap_mask = ((ADDR_W'(r_len) + ADDR_W'(1)) << r_size) - ADDR_W'(1);

   always_comb begin
      w_addr_next = r_addr;
      case (r_burst)
         2'b01:   w_addr_next = w_incr_addr;
         2'b10:   w_addr_next = (r_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask);
         default: w_addr_next = r_addr;
      endcase
   end

   // Burst length comes from AWLEN; WLAST only flags a protocol error when it disagrees.
   assign w_last_beat = (r_cnt == r_len);
   assign w_resp_fin  = ((r_resp == 2'b00) && (WLAST != w_last_beat)) ? 2'b10 : r_resp;

`ifdef AXI_WR_MEM_LANE_MASK_EN
   localparam int SW1 = STRB_W + 1;
   logic [ADDR_W-1:0] w_lane_off;
   logic [STRB_W:0]   w_lane_ones;
   assign w_lane_off  = r_addr & ADDR_W'(STRB_W - 1) & ~w_size_mask;
   assign w_lane_ones = (SW1'(1) << (ADDR_W'(1) << r_size)) - SW1'(1);
   assign w_be        = WSTRB & (STRB_W'(w_lane_ones) << w_lane_off);
`else
   assign w_be = WSTRB;
`endif

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         r_state     <= S_IDLE;
         r_id        <= '0;
         r_addr      <= '0;
         r_len       <= '0;
         r_size      <= '0;
         r_burst     <= '0;
         r_cnt       <= '0;
         r_resp      <= 2'b00;
         r_wsup      <= 1'b0;
         r_awready   <= 1'b1;
         r_wready    <= 1'b0;
         r_bvalid    <= 1'b0;
         r_bid       <= '0;
         r_bresp     <= 2'b00;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
      end else begin
         r_mem_we <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (AWVALID && r_awready) begin
                  r_id      <= AWID;
                  r_addr    <= AWADDR;
                  r_len     <= AWLEN;
                  r_size    <= AWSIZE;
                  r_burst   <= AWBURST;
                  r_cnt     <= 8'd0;
                  r_resp    <= w_slverr ? 2'b10 : (w_decerr ? 2'b11 : 2'b00);
                  r_wsup    <= w_slverr || w_decerr;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b1;
                  r_state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (WVALID && r_wready) begin
                  r_mem_we    <= !r_wsup;
                  r_mem_addr  <= MEM_AW'(r_addr >> LB);
                  r_mem_wdata <= WDATA;
                  r_mem_be    <= w_be;
                  r_addr      <= w_addr_next;
                  r_cnt       <= r_cnt + 8'd1;
                  r_resp      <= w_resp_fin;
                  if (w_last_beat) begin
                     r_wready <= 1'b0;
                     r_bvalid <= 1'b1;
                     r_bid    <= r_id;
                     r_bresp  <= w_resp_fin;
                     r_state  <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               if (BREADY) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign AWREADY   = r_awready;
   assign WREADY    = r_wready;
   assign BVALID    = r_bvalid;
   assign BID       = r_bid;
   assign BRESP     = r_bresp;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_be    = r_mem_be;
endmodule

// File: tb/tb_axi4_wr_mem_slave.sv
// Directed bench for axi4_wr_mem_slave: a burst table plus hand sequences for stalls and reset.
module tb_axi4_wr_mem_slave;
   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic        AWID = 1'b0;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [31:0] AWADDR = '0;
   logic [7:0]  AWLEN = '0;
   logic [2:0]  AWSIZE = '0;
   logic [1:0]  AWBURST = '0;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic [31:0] WDATA = '0;
   logic [3:0]  WSTRB = '0;
   logic        WLAST = 1'b0;
   logic        BID;
   logic        BVALID;
   logic        BREADY = 1'b0;
   logic [1:0]  BRESP;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;

   int total = 0;
   int bad = 0;

   axi4_wr_mem_slave dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWID(AWID), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
      .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
      .BID(BID), .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be)
   );

   always #5 ACLK = ~ACLK;

   typedef struct packed {
      logic [31:0]      addr;
      logic [7:0]       len;
      logic [2:0]       size;
      logic [1:0]       burst;
      logic             id;
      logic [3:0]       strb;
      int               last_at;
      logic             wr;
      logic [1:0]       resp;
      logic [3:0][9:0]  a;
      logic [3:0][3:0]  be;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return AWREADY;
         1:       return WREADY;
         default: return BVALID;
      endcase
   endfunction

   // Waits (bounded) until the selected output is high; sampled #1 after an edge.
   task automatic wait_hi(input int sel);
      for (int i = 0; i < 20; i++) begin
         if (sig(sel)) return;
         @(posedge ACLK); #1;
      end
      chk($sformatf("timeout_sel%0d", sel), 32'(sig(sel)), 32'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_awready"}, 32'(AWREADY), 32'd1);
      chk({tag, "_wready"}, 32'(WREADY), 32'd0);
      chk({tag, "_bvalid"}, 32'(BVALID), 32'd0);
      chk({tag, "_bid"}, 32'(BID), 32'd0);
      chk({tag, "_bresp"}, 32'(BRESP), 32'd0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
   endtask

   task automatic do_aw(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] burst, input logic id);
      AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWID = id; AWVALID = 1'b1;
      wait_hi(0);
      @(posedge ACLK); #1;
      AWVALID = 1'b0;
   endtask

   task automatic run_burst(input int vi, input vec_t v);
      do_aw(v.addr, v.len, v.size, v.burst, v.id);
      for (int b = 0; b <= int'(v.len); b++) begin
         WDATA = {8'(vi), 8'(b), 16'hA5C3};
         WSTRB = v.strb;
         WLAST = (b == v.last_at);
         WVALID = 1'b1;
         wait_hi(1);
         @(posedge ACLK); #1;
         if (v.wr) begin
            chk($sformatf("v%0d_b%0d_we", vi, b), 32'(mem_we), 32'd1);
            chk($sformatf("v%0d_b%0d_addr", vi, b), 32'(mem_addr), 32'(v.a[b]));
            chk($sformatf("v%0d_b%0d_be", vi, b), 32'(mem_be), 32'(v.be[b]));
            chk($sformatf("v%0d_b%0d_data", vi, b), mem_wdata, {8'(vi), 8'(b), 16'hA5C3});
         end else begin
            chk($sformatf("v%0d_b%0d_we_supp", vi, b), 32'(mem_we), 32'd0);
         end
      end
      WVALID = 1'b0; WLAST = 1'b0;
      chk($sformatf("v%0d_bvalid", vi), 32'(BVALID), 32'd1);
      chk($sformatf("v%0d_bresp", vi), 32'(BRESP), 32'(v.resp));
      chk($sformatf("v%0d_bid", vi), 32'(BID), 32'(v.id));
      BREADY = 1'b1;
      @(posedge ACLK); #1;
      BREADY = 1'b0;
      chk($sformatf("v%0d_bvalid_drop", vi), 32'(BVALID), 32'd0);
      chk($sformatf("v%0d_awready_back", vi), 32'(AWREADY), 32'd1);
      $display("burst %0d addr=%h len=%0d size=%0d burst=%0d resp=%0d", vi, v.addr, v.len, v.size,
               v.burst, BRESP);
   endtask

   function automatic vec_t mk(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic id, input logic [3:0] strb,
                               input int last_at, input logic wr, input logic [1:0] resp,
                               input logic [3:0][9:0] a, input logic [3:0][3:0] be);
      vec_t v;
      v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.id = id; v.strb = strb;
      v.last_at = last_at; v.wr = wr; v.resp = resp; v.a = a; v.be = be;
      return v;
   endfunction

   initial begin
      // Address/byte-enable lists are written highest beat first.
      vecs[0]  = mk(32'h100, 3, 2, 2'b01, 1, 4'hF, 3, 1, 2'b00, {10'h043, 10'h042, 10'h041, 10'h040}, 16'hFFFF);
      vecs[1]  = mk(32'h038, 3, 2, 2'b10, 0, 4'hF, 3, 1, 2'b00, {10'h00D, 10'h00C, 10'h00F, 10'h00E}, 16'hFFFF);
      vecs[2]  = mk(32'h000, 1, 2, 2'b11, 1, 4'hF, 1, 0, 2'b10, '0, '0);
      vecs[3]  = mk(32'h1000, 1, 2, 2'b01, 0, 4'hF, 1, 0, 2'b11, '0, '0);
      vecs[4]  = mk(32'h102, 2, 2, 2'b01, 1, 4'hF, 2, 1, 2'b00, {10'h000, 10'h042, 10'h041, 10'h040}, 16'hFFFF);
      vecs[5]  = mk(32'hFF8, 3, 2, 2'b01, 0, 4'h5, 3, 1, 2'b00, {10'h001, 10'h000, 10'h3FF, 10'h3FE}, 16'h5555);
`ifdef AXI_WR_MEM_LANE_MASK_EN
      vecs[6]  = mk(32'h010, 3, 1, 2'b01, 1, 4'hF, 3, 1, 2'b00, {10'h005, 10'h005, 10'h004, 10'h004}, 16'hC3C3);
      vecs[11] = mk(32'h102, 0, 0, 2'b01, 1, 4'hF, 0, 1, 2'b00, {30'h0, 10'h040}, 16'h0004);
`else
      vecs[6]  = mk(32'h010, 3, 1, 2'b01, 1, 4'hF, 3, 1, 2'b00, {10'h005, 10'h005, 10'h004, 10'h004}, 16'hFFFF);
      vecs[11] = mk(32'h102, 0, 0, 2'b01, 1, 4'hF, 0, 1, 2'b00, {30'h0, 10'h040}, 16'h000F);
`endif
      vecs[7]  = mk(32'h000, 0, 3, 2'b01, 0, 4'hF, 0, 0, 2'b10, '0, '0);
      vecs[8]  = mk(32'h000, 2, 2, 2'b10, 1, 4'hF, 2, 0, 2'b10, '0, '0);
      vecs[9]  = mk(32'h000, 3, 2, 2'b01, 0, 4'hF, 1, 1, 2'b10, {10'h003, 10'h002, 10'h001, 10'h000}, 16'hFFFF);
      vecs[10] = mk(32'h200, 1, 2, 2'b01, 1, 4'hF, 9, 1, 2'b10, {20'h0, 10'h081, 10'h080}, 16'hFFFF);

      repeat (3) @(posedge ACLK);
      #1;
      chk_reset_vals("reset");
      ARESETn = 1'b1;
      @(posedge ACLK); #1;

      // W beats offered before any AW must be ignored.
      WVALID = 1'b1; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; WLAST = 1'b1;
      repeat (2) begin
         @(posedge ACLK); #1;
         chk("early_w_wready", 32'(WREADY), 32'd0);
         chk("early_w_we", 32'(mem_we), 32'd0);
      end
      WVALID = 1'b0; WLAST = 1'b0;

      for (int i = 0; i < 12; i++) run_burst(i, vecs[i]);

      // FIXED burst with gapped WVALID and a stalled B channel.
      do_aw(32'h20, 8'd2, 3'd2, 2'b00, 1'b1);
      for (int b = 0; b < 3; b++) begin
         WVALID = 1'b0;
         @(posedge ACLK); #1;
         chk($sformatf("fixed_gap%0d_we", b), 32'(mem_we), 32'd0);
         WVALID = 1'b1; WDATA = 32'(b) + 32'h77; WSTRB = 4'hF; WLAST = (b == 2);
         @(posedge ACLK); #1;
         chk($sformatf("fixed_b%0d_we", b), 32'(mem_we), 32'd1);
         chk($sformatf("fixed_b%0d_addr", b), 32'(mem_addr), 32'h008);
      end
      WVALID = 1'b0; WLAST = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("stall%0d_bvalid", c), 32'(BVALID), 32'd1);
         chk($sformatf("stall%0d_awready", c), 32'(AWREADY), 32'd0);
         @(posedge ACLK); #1;
      end
      chk("fixed_bresp", 32'(BRESP), 32'd0);
      BREADY = 1'b1;
      @(posedge ACLK); #1;
      BREADY = 1'b0;
      chk("fixed_bvalid_drop", 32'(BVALID), 32'd0);
      chk("fixed_awready_back", 32'(AWREADY), 32'd1);
      $display("burst fixed addr=00000020 len=2 stalled B 5 cycles");

      // Reset during beat 2 abandons the burst.
      do_aw(32'h40, 8'd3, 3'd2, 2'b01, 1'b1);
      WVALID = 1'b1; WDATA = 32'h1111_1111; WSTRB = 4'hF;
      wait_hi(1);
      @(posedge ACLK); #1;
      chk("rst_b0_we", 32'(mem_we), 32'd1);
      WDATA = 32'h2222_2222;
      ARESETn = 1'b0;
      @(posedge ACLK); #1;
      WVALID = 1'b0;
      chk_reset_vals("midrst");
      ARESETn = 1'b1;
      repeat (3) begin
         @(posedge ACLK); #1;
         chk("post_rst_bvalid", 32'(BVALID), 32'd0);
         chk("post_rst_awready", 32'(AWREADY), 32'd1);
      end
      $display("burst reset-abandon addr=00000040");
      run_burst(0, vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/axi4_wr_mem_slave.md
Name: axi4_wr_mem_slave

Overview:
AXI4 write-channel responder (slave end of the AXI4 write interface) that accepts one burst at a time and drives a simple synchronous SRAM-style write port. It decodes FIXED, INCR and WRAP bursts, generates per-beat word addresses and byte enables, and returns a B response with the captured ID. It sits between an AXI4 write master (DMA, interconnect) and on-chip block RAM.

Parameters:
ID_W, 1, AXI ID width
ADDR_W, 32, AXI byte address width
DATA_W, 32, data width in bits; power of 2, >= 8
MEM_AW, 10, memory word-address width; memory spans 2**MEM_AW words of DATA_W

Ports:
ACLK  in  1  clock
ARESETn  in  1  synchronous active-low reset
AWID  in  ID_W  write address ID
AWVALID  in  1  address valid
AWREADY  out  1  address ready
AWADDR  in  ADDR_W  burst start byte address
AWLEN  in  8  beats minus 1
AWSIZE  in  3  log2 bytes per beat
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
WVALID  in  1  data valid
WREADY  out  1  data ready
WDATA  in  DATA_W  write data
WSTRB  in  DATA_W/8  byte strobes
WLAST  in  1  last beat marker
BID  out  ID_W  response ID
BVALID  out  1  response valid
BREADY  in  1  response ready
BRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR
mem_we  out  1  memory write strobe
mem_addr  out  MEM_AW  memory word address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables

Behaviour:
- Reset (ARESETn sampled low at ACLK edge): state IDLE; AWREADY=1, WREADY=0, BVALID=0, BID=0, BRESP=00, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0. Reset mid-burst abandons the burst; no B response is issued.
- FSM IDLE -> DATA -> RESP -> IDLE. AWREADY=1 only in IDLE; WREADY=1 only in DATA; BVALID=1 only in RESP. All outputs registered.
- IDLE: on AWVALID&AWREADY capture AWID, AWADDR, AWLEN, AWSIZE, AWBURST; clear error flag; beat counter=0; go to DATA (WREADY high the next cycle). W beats presented before AW are not accepted.
- Error check at AW capture: AWBURST=11, AWSIZE > log2(DATA_W/8), or WRAP with AWLEN not in {1,3,7,15} -> SLVERR. Any address bit at or above MEM_AW+log2(DATA_W/8) set -> DECERR (SLVERR takes priority). On either error all memory writes of the burst are suppressed; data beats are still consumed.
- DATA: each W handshake at cycle n gives mem_we=1 at n+1 with mem_addr = current byte address >> log2(DATA_W/8) truncated to MEM_AW, mem_wdata=WDATA, mem_be=WSTRB. mem_we=0 in cycles with no handshake.
- Address update per beat: FIXED unchanged; INCR addr = aligned(addr, size) + (1<<size), so an unaligned start aligns from beat 2; WRAP wraps within a boundary of (AWLEN+1)<<AWSIZE bytes, lower bits wrap, upper bits held. INCR beyond the top of memory wraps mod 2**MEM_AW words.
- Beat count governs burst end: handshake with counter==AWLEN -> RESP at n+1. WLAST=1 on an earlier beat, or WLAST=0 on the final beat -> SLVERR (if no error already set); writes are still performed.
- RESP: BVALID=1, BID=captured ID, BRESP per error flag (OKAY if none). BVALID holds until BREADY; on BVALID&BREADY go to IDLE, AWREADY=1 the next cycle.
- Throughput: with AWVALID, WVALID and BREADY held high, one beat per cycle in DATA; per-burst overhead is 2 idle cycles (AW and B).

Optional Feature:
AXI_WR_MEM_LANE_MASK_EN: when defined, mem_be = WSTRB AND the lane mask for the current address and size: (1<<AWSIZE) lanes starting at addr[log2(DATA_W/8)-1:0] aligned down to size. This protects against strobes outside the active narrow-transfer lanes. When not defined, mem_be = WSTRB unmodified.

Test Plan:
- INCR AWADDR=0x100, AWLEN=3, size=2 (DATA_W=32), 4 beats with WSTRB=F, WLAST on beat 4 -> mem_addr 0x40,0x41,0x42,0x43, each 1 cycle after its handshake; BRESP=00, BID=AWID.
- WRAP AWADDR=0x38, AWLEN=3, size=2 -> mem_addr 0x0E,0x0F,0x0C,0x0D; BRESP=00.
- FIXED AWADDR=0x20, AWLEN=2, WVALID toggling every other cycle -> 3 writes to 0x08, only on handshake cycles; BREADY held low 5 cycles -> BVALID stays high and AWREADY stays low until BREADY.
- AWBURST=11, AWLEN=1 -> 2 beats consumed, mem_we never asserted, BRESP=10. Separately, AWADDR=0x1000 (MEM_AW=10) -> BRESP=11 with no writes.
- WLAST asserted on beat 2 of AWLEN=3 -> 4 writes performed, BRESP=10; ARESETn low during beat 2 of a new burst -> all outputs at reset values, no BVALID, AWREADY=1 after reset.
- With AXI_WR_MEM_LANE_MASK_EN, size=0 write at AWADDR=0x102 with WSTRB=F -> mem_be=4'b0100. Without the macro -> mem_be=4'hF.
